data_memory_lsu: RTL and testbench
==================================

Name: data_memory_lsu

Overview:
- Byte-addressed data memory with a built-in load/store unit for the pipeline MEM stage.
- Next generation of the 32-bit async-read byte RAM:
  - byte/half/word store widths with byte enables
  - sign/zero-extended loads
  - registered (1-cycle) read latency
  - misalignment detection
  - sequential word-dump engine so the debug unit can stream memory contents out.
- Sits between the EX/MEM pipeline register and MEM/WB; the dump port feeds the debug/UART unit.

Parameters:
- DATA_WIDTH, 8, bits per addressable byte lane; word = 4*DATA_WIDTH.
- ADDR_WIDTH, 12, byte-address width; storage = 2**ADDR_WIDTH lanes.

Ports:
- i_clk  input  1  clock, all state on rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_req  input  1  access request this cycle.
- i_we  input  1  1=store, 0=load.
- i_width  input  2  00 byte, 01 half, 10 word, 11 illegal.
- i_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
- i_addr  input  ADDR_WIDTH  byte address.
- i_wdata  input  4*DATA_WIDTH  store data, right-aligned (low lanes used for byte/half).
- o_rdata  output  4*DATA_WIDTH  extended load result.
- o_rvalid  output  1  one-cycle pulse: o_rdata valid.
- o_error  output  1  one-cycle pulse: misaligned/illegal access.
- o_busy  output  1  dump in progress; requests ignored.
- i_dump_start  input  1  start full-memory dump (pulse).
- i_dump_ready  input  1  consumer accepts current dump word.
- o_dump_valid  output  1  dump word presented.
- o_dump_addr  output  ADDR_WIDTH  byte address of dump word.
- o_dump_data  output  4*DATA_WIDTH  dump word, little-endian lanes.
- o_dump_done  output  1  one-cycle pulse after last word accepted.

Behaviour:
- Reset: all outputs 0; FSM to IDLE. Memory contents are not cleared by reset.
- Alignment:
  - half requires addr[0]=0; word requires addr[1:0]=0.
  - width 11 is always an error.
  - Errored access: no write; o_error=1 next cycle; o_rvalid=0; o_rdata=0.
- Accepted access: i_req=1, o_busy=0, no error.
- Store: lanes addr..addr+N-1 written at the accepting edge, little-endian (lane 0 of i_wdata at addr). No o_rvalid.
- Load:
  - Lanes sampled at the accepting edge.
  - Next cycle: o_rvalid=1 with o_rdata extended to 4*DATA_WIDTH per i_unsigned.
  - Word loads ignore i_unsigned.
  - o_rdata holds its value until the next load or error.
- Latency: load 1 cycle. Back-to-back requests every cycle are allowed.
- Load one cycle after a store to the same address returns the newly stored data.
- Address wrap: not possible for aligned accesses; byte lanes never wrap.
- Dump FSM:
  - IDLE: on i_dump_start, go to DUMP with ptr=0. A request arriving in the same cycle as start is still served, because o_busy is 0 in that cycle.
  - DUMP: o_busy=1 and o_dump_valid=1, with o_dump_addr=ptr and o_dump_data=word at ptr (registered, 1-cycle fill after each ptr change). Valid is deasserted during the fill cycle. Data is stable while valid=1 and ready=0. On valid&ready, ptr+=4. After ptr=2**ADDR_WIDTH-4 is accepted, go to DONE.
  - DONE: o_dump_done=1 for one cycle, then IDLE.
  - i_dump_start outside IDLE is ignored.
  - i_req while busy is dropped: no write, no rvalid, no error.
- Reset mid-dump: immediate return to IDLE; dump outputs 0; no done pulse.

Optional Feature:
- DMEM_DUMP_EN defined: dump FSM and the dump ports operate as described above.
- Not defined:
  - No FSM is built; i_dump_start and i_dump_ready are ignored.
  - o_busy, o_dump_valid, o_dump_done, o_dump_addr and o_dump_data are constant 0.
  - The load/store path is unchanged.

Decomposition:
- Shared package/header dmem_pkg:
  - width codes W_BYTE=2'b00, W_HALF=2'b01, W_WORD=2'b10
  - dump FSM state encodings IDLE/DUMP/DONE
  - word-bytes constant 4
- Sub-module dmem_byte_array: 4-lane storage with a per-lane write-enable vector, one synchronous word read port muxed between the LSU and the dump pointer.
- Top level holds the alignment check, extension logic and the dump FSM.

Test Plan:
- Store word 0xDEADBEEF @0x010, load word @0x010 next cycle -> o_rvalid=1 one cycle later, o_rdata=0xDEADBEEF.
- Store byte 0x80 @0x013, then:
  - load byte signed @0x013 -> 0xFFFFFF80
  - load byte unsigned @0x013 -> 0x00000080
  - load word @0x010 -> 0x80ADBEEF
- Load half @0x011; store word @0x022; any access with width=11 -> o_error pulse; o_rdata=0; memory unchanged; no o_rvalid.
- ADDR_WIDTH=4, memory preloaded, assert i_dump_start, ready toggled 1/0 -> 4 words at addrs 0,4,8,12 with stable data while stalled. Then o_dump_done one pulse; o_busy high throughout; i_req store during dump leaves memory unchanged.
- Assert i_reset after the 2nd dump word -> all outputs 0 and FSM IDLE. Subsequent load @0x0 returns the preloaded value (contents survive reset).
- Build without DMEM_DUMP_EN, pulse i_dump_start -> o_busy and o_dump_valid stay 0; loads/stores still respond in 1 cycle.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory / load-store unit: access width codes,
// dump FSM state encoding and per-access lane helpers.
package dmem_pkg;

    localparam int WORD_BYTES = 4;

    localparam logic [1:0] W_BYTE = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DUMP = 2'b01,
        DONE = 2'b10
    } dump_state_t;

    // Width 2'b11 has no legal form, so it always reports as misaligned.
    function automatic logic misaligned(input logic [1:0] width, input logic [1:0] offset);
        case (width)
            W_BYTE:  return 1'b0;
            W_HALF:  return offset[0];
            W_WORD:  return offset != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [WORD_BYTES-1:0] lane_mask(input logic [1:0] width);
        case (width)
            W_BYTE:  return 4'b0001;
            W_HALF:  return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/dmem_byte_array.sv
// Four byte-lane storage banks with per-lane write enables and one registered
// word read port; a whole aligned word lives in a single row.
module dmem_byte_array
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ROW_WIDTH  = 10
) (
    input  logic                             clk,
    input  logic [WORD_BYTES-1:0]            wr_en,
    input  logic [ROW_WIDTH-1:0]             wr_row,
    input  logic [WORD_BYTES*DATA_WIDTH-1:0] wr_data,
    input  logic                             rd_en,
    input  logic [ROW_WIDTH-1:0]             rd_row,
    output logic [WORD_BYTES*DATA_WIDTH-1:0] rd_data
);

    // NOTE: the storage and its read register take no reset so they map onto RAM
    // macros; contents deliberately survive a reset of the surrounding logic.
    for (genvar lane = 0; lane < WORD_BYTES; lane++) begin : g_lane
        logic [DATA_WIDTH-1:0] mem [2**ROW_WIDTH];
        logic [DATA_WIDTH-1:0] rd_q;

        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        always_ff @(posedge clk) begin
            if (wr_en[lane]) mem[wr_row] <= wr_data[lane*DATA_WIDTH +: DATA_WIDTH];
            if (rd_en)       rd_q        <= mem[rd_row];
        end

        assign rd_data[lane*DATA_WIDTH +: DATA_WIDTH] = rd_q;
    end

endmodule

// File: rtl/data_memory_lsu.sv
// Byte-addressed data memory with load/store unit for the MEM stage.
// Define DMEM_DUMP_EN to build the sequential word-dump engine for the debug unit.
module data_memory_lsu
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                             i_clk,
    input  logic                             i_reset,
    input  logic                             i_req,
    input  logic                             i_we,
    input  logic [1:0]                       i_width,
    input  logic                             i_unsigned,
    input  logic [ADDR_WIDTH-1:0]            i_addr,
    input  logic [WORD_BYTES*DATA_WIDTH-1:0] i_wdata,
    output logic [WORD_BYTES*DATA_WIDTH-1:0] o_rdata,
    output logic                             o_rvalid,
    output logic                             o_error,
    output logic                             o_busy,
    input  logic                             i_dump_start,
    input  logic                             i_dump_ready,
    output logic                             o_dump_valid,
    output logic [ADDR_WIDTH-1:0]            o_dump_addr,
    output logic [WORD_BYTES*DATA_WIDTH-1:0] o_dump_data,
    output logic                             o_dump_done
);

    localparam int WORD_W = WORD_BYTES * DATA_WIDTH;
    localparam int ROW_W  = ADDR_WIDTH - 2;

    logic [1:0]            offset;
    logic [ROW_W-1:0]      row;
    logic                  busy;
    logic                  dump_rd;
    logic [ROW_W-1:0]      dump_row;
    logic                  dump_valid;
    logic                  dump_done;
    logic                  take;
    logic                  bad;
    logic                  do_store;
    logic                  do_load;
    logic                  do_error;
    logic [WORD_BYTES-1:0] wr_en;
    logic [WORD_W-1:0]     wr_data;
    logic [WORD_W-1:0]     rd_data;

    assign offset   = i_addr[1:0];
    assign row      = i_addr[ADDR_WIDTH-1:2];
    assign take     = i_req & ~busy;
    assign bad      = misaligned(i_width, offset);
    assign do_store = take & ~bad & i_we;
    assign do_load  = take & ~bad & ~i_we;
    assign do_error = take & bad;

    // Right-aligned store data is steered onto the lanes starting at the byte offset.
    assign wr_en   = do_store ? (lane_mask(i_width) << offset) : '0;
    assign wr_data = i_wdata << (DATA_WIDTH * offset);

    dmem_byte_array #(
        .DATA_WIDTH(DATA_WIDTH),
        .ROW_WIDTH (ROW_W)
    ) u_array (
        .clk    (i_clk),
        .wr_en  (wr_en),
        .wr_row (row),
        .wr_data(wr_data),
        .rd_en  (do_load | dump_rd),
        .rd_row (busy ? dump_row : row),
        .rd_data(rd_data)
    );

    logic              load_pend;
    logic              err_q;
    logic [1:0]        ld_offset;
    logic [1:0]        ld_width;
    logic              ld_unsigned;
    logic [WORD_W-1:0] hold;
    logic [WORD_W-1:0] lane_data;
    logic [WORD_W-1:0] ext;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            load_pend   <= 1'b0;
            err_q       <= 1'b0;
            ld_offset   <= '0;
            ld_width    <= '0;
            ld_unsigned <= 1'b0;
            hold        <= '0;
        end else begin
            load_pend <= do_load;
            err_q     <= do_error;
            if (load_pend) hold <= ext;
            if (do_error)  hold <= '0;
            if (do_load) begin
                ld_offset   <= offset;
                ld_width    <= i_width;
                ld_unsigned <= i_unsigned;
            end
        end
    end

    // NOTE: ext gets a value before the case so no path through the block infers a latch.
    always_comb begin
        lane_data = rd_data >> (DATA_WIDTH * ld_offset);
        ext       = lane_data;
        case (ld_width)
            W_BYTE: ext = {{(WORD_W-DATA_WIDTH){~ld_unsigned & lane_data[DATA_WIDTH-1]}},
                           lane_data[DATA_WIDTH-1:0]};
            W_HALF: ext = {{(WORD_W-2*DATA_WIDTH){~ld_unsigned & lane_data[2*DATA_WIDTH-1]}},
                           lane_data[2*DATA_WIDTH-1:0]};
            default: ext = lane_data;
        endcase
    end

    // The result register only follows the array during the cycle a load returns.
    assign o_rdata  = load_pend ? ext : hold;
    assign o_rvalid = load_pend;
    assign o_error  = err_q;

`ifdef DMEM_DUMP_EN
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(2**ADDR_WIDTH - WORD_BYTES);
    localparam logic [ADDR_WIDTH-1:0] STEP     = ADDR_WIDTH'(WORD_BYTES);

    dump_state_t           state;
    dump_state_t           state_next;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [ADDR_WIDTH-1:0] ptr_next;
    logic                  fill;
    logic                  fill_next;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
            ptr   <= '0;
            fill  <= 1'b0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
            fill  <= fill_next;
        end
    end

    // fill marks the cycle in which the word at a fresh ptr is being read out.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        fill_next  = fill;
        busy       = 1'b0;
        dump_valid = 1'b0;
        dump_done  = 1'b0;
        dump_rd    = 1'b0;
        case (state)
            IDLE: begin
                if (i_dump_start) begin
                    state_next = DUMP;
                    ptr_next   = '0;
                    fill_next  = 1'b1;
                end
            end
            DUMP: begin
                busy       = 1'b1;
                dump_valid = ~fill;
                dump_rd    = fill;
                fill_next  = 1'b0;
                if (!fill && i_dump_ready) begin
                    if (ptr == LAST_PTR) begin
                        state_next = DONE;
                    end else begin
                        ptr_next  = ptr + STEP;
                        fill_next = 1'b1;
                    end
                end
            end
            DONE: begin
                busy       = 1'b1;
                dump_done  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign dump_row    = ptr[ADDR_WIDTH-1:2];
    assign o_dump_addr = (state == DUMP) ? ptr : '0;
`else
    logic unused_dump;

    assign unused_dump = i_dump_start ^ i_dump_ready;
    assign busy        = 1'b0;
    assign dump_valid  = 1'b0;
    assign dump_done   = 1'b0;
    assign dump_rd     = 1'b0;
    assign dump_row    = '0;
    assign o_dump_addr = '0;
`endif

    assign o_busy       = busy;
    assign o_dump_valid = dump_valid;
    assign o_dump_done  = dump_done;
    assign o_dump_data  = dump_valid ? rd_data : '0;

endmodule

// File: tb/tb_data_memory_lsu.sv
// Bench for data_memory_lsu: a byte-level reference model checks the 4 KiB instance
// every cycle; a 16-byte instance exercises the dump port (or its absence).
module tb_data_memory_lsu;

    localparam logic [1:0] BYTE = 2'b00;
    localparam logic [1:0] HALF = 2'b01;
    localparam logic [1:0] WORD = 2'b10;
    localparam logic [1:0] ILL  = 2'b11;

    int vectors = 0;
    int errors  = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        m_req = 1'b0, m_we = 1'b0, m_uns = 1'b0, m_start = 1'b0, m_ready = 1'b0;
    logic [1:0]  m_width = '0;
    logic [11:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [31:0] m_rdata, m_ddata;
    logic [11:0] m_daddr;
    logic        m_rvalid, m_error, m_busy, m_dvalid, m_done;

    data_memory_lsu dut (
        .i_clk(clk), .i_reset(rst), .i_req(m_req), .i_we(m_we), .i_width(m_width),
        .i_unsigned(m_uns), .i_addr(m_addr), .i_wdata(m_wdata), .o_rdata(m_rdata),
        .o_rvalid(m_rvalid), .o_error(m_error), .o_busy(m_busy), .i_dump_start(m_start),
        .i_dump_ready(m_ready), .o_dump_valid(m_dvalid), .o_dump_addr(m_daddr),
        .o_dump_data(m_ddata), .o_dump_done(m_done)
    );

    logic        s_rst = 1'b1;
    logic        s_req = 1'b0, s_we = 1'b0, s_uns = 1'b0, s_start = 1'b0, s_ready = 1'b0;
    logic [1:0]  s_width = '0;
    logic [3:0]  s_addr = '0;
    logic [31:0] s_wdata = '0;
    logic [31:0] s_rdata, s_ddata;
    logic [3:0]  s_daddr;
    logic        s_rvalid, s_error, s_busy, s_dvalid, s_done;

    data_memory_lsu #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) sdut (
        .i_clk(clk), .i_reset(s_rst), .i_req(s_req), .i_we(s_we), .i_width(s_width),
        .i_unsigned(s_uns), .i_addr(s_addr), .i_wdata(s_wdata), .o_rdata(s_rdata),
        .o_rvalid(s_rvalid), .o_error(s_error), .o_busy(s_busy), .i_dump_start(s_start),
        .i_dump_ready(s_ready), .o_dump_valid(s_dvalid), .o_dump_addr(s_daddr),
        .o_dump_data(s_ddata), .o_dump_done(s_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    // Reference model: memory as a flat byte array, rules applied per access.
    typedef struct packed {
        logic        rvalid;
        logic        error;
        logic [31:0] rdata;
    } exp_t;

    logic [7:0] mem_m [4096];
    exp_t       expd;

    function automatic exp_t model_access(input exp_t prev, input logic req, input logic we,
                                          input logic [1:0] width, input logic uns,
                                          input int addr, input logic [31:0] wdata);
        exp_t        e;
        int          n;
        logic [31:0] v;
        e        = prev;
        e.rvalid = 1'b0;
        e.error  = 1'b0;
        if (!req) return e;
        n = (width == BYTE) ? 1 : (width == HALF) ? 2 : (width == WORD) ? 4 : 0;
        if (n == 0 || (addr % n) != 0) begin
            e.error = 1'b1;
            e.rdata = '0;
            return e;
        end
        if (we) begin
            for (int i = 0; i < n; i++) mem_m[addr+i] = wdata[8*i +: 8];
            return e;
        end
        v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = mem_m[addr+i];
        if (n < 4 && !uns && v[8*n-1]) for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
        e.rvalid = 1'b1;
        e.rdata  = v;
        return e;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) expd <= '0;
        else     expd <= model_access(expd, m_req, m_we, m_width, m_uns, int'(m_addr), m_wdata);
    end

    always @(negedge clk) begin
        check("m_rvalid", 32'(m_rvalid), 32'(expd.rvalid));
        check("m_error", 32'(m_error), 32'(expd.error));
        check("m_rdata", m_rdata, expd.rdata);
        check("m_busy", 32'(m_busy), 32'd0);
        check("m_dump_valid", 32'(m_dvalid), 32'd0);
        check("m_dump_done", 32'(m_done), 32'd0);
    end

    task automatic mdrive(input logic req, input logic we, input logic [1:0] width,
                          input logic uns, input logic [11:0] addr, input logic [31:0] wdata);
        m_req = req; m_we = we; m_width = width; m_uns = uns; m_addr = addr; m_wdata = wdata;
        @(negedge clk);
    endtask

    task automatic sdrive(input logic req, input logic we, input logic [1:0] width,
                          input logic uns, input logic [3:0] addr, input logic [31:0] wdata);
        s_req = req; s_we = we; s_width = width; s_uns = uns; s_addr = addr; s_wdata = wdata;
        @(negedge clk);
    endtask

    logic [31:0] sw [4] = '{32'h03020100, 32'h17161514, 32'h2B2A2928, 32'h3F3E3D3C};

    initial begin
        int          k;
        logic        got_done;
        logic        stalled;
        logic [31:0] stall_data;

        repeat (2) @(negedge clk);
        check("rst_rdata", m_rdata, 32'h0);
        check("rst_s_busy", 32'(s_busy), 32'd0);
        check("rst_s_ddata", s_ddata, 32'h0);
        rst = 1'b0;
        s_rst = 1'b0;

        mdrive(1, 1, WORD, 0, 12'h010, 32'hDEADBEEF);
        mdrive(1, 0, WORD, 0, 12'h010, 0);
        check("ld_word_rvalid", 32'(m_rvalid), 32'd1);
        check("ld_word", m_rdata, 32'hDEADBEEF);
        mdrive(1, 1, BYTE, 0, 12'h013, 32'hAAAAAA80);
        mdrive(1, 0, BYTE, 0, 12'h013, 0);
        check("ld_byte_signed", m_rdata, 32'hFFFFFF80);
        mdrive(1, 0, BYTE, 1, 12'h013, 0);
        check("ld_byte_unsigned", m_rdata, 32'h00000080);
        mdrive(1, 0, WORD, 1, 12'h010, 0);
        check("ld_word_after_byte", m_rdata, 32'h80ADBEEF);
        mdrive(1, 1, WORD, 0, 12'h020, 32'h11223344);
        mdrive(1, 1, WORD, 0, 12'h024, 32'h55667788);

        mdrive(1, 0, HALF, 0, 12'h011, 0);
        check("misaligned_half_error", 32'(m_error), 32'd1);
        check("misaligned_half_rvalid", 32'(m_rvalid), 32'd0);
        check("misaligned_half_rdata", m_rdata, 32'h0);
        mdrive(1, 1, WORD, 0, 12'h022, 32'h12345678);
        check("misaligned_word_error", 32'(m_error), 32'd1);
        mdrive(1, 0, ILL, 0, 12'h010, 0);
        check("illegal_load_error", 32'(m_error), 32'd1);
        mdrive(1, 1, ILL, 0, 12'h020, 32'hFFFFFFFF);
        check("illegal_store_error", 32'(m_error), 32'd1);
        mdrive(1, 0, WORD, 0, 12'h020, 0);
        check("unchanged_020", m_rdata, 32'h11223344);
        mdrive(1, 0, WORD, 0, 12'h024, 0);
        check("unchanged_024", m_rdata, 32'h55667788);

        mdrive(1, 1, HALF, 0, 12'h012, 32'hFFFF8001);
        mdrive(1, 0, HALF, 0, 12'h012, 0);
        check("ld_half_signed", m_rdata, 32'hFFFF8001);
        mdrive(1, 0, HALF, 1, 12'h012, 0);
        check("ld_half_unsigned", m_rdata, 32'h00008001);
        mdrive(1, 0, BYTE, 0, 12'h012, 0);
        check("ld_byte_positive", m_rdata, 32'h00000001);
        mdrive(1, 0, WORD, 0, 12'h010, 0);
        check("ld_word_after_half", m_rdata, 32'h8001BEEF);

        mdrive(1, 1, WORD, 0, 12'hFFC, 32'hCAFEF00D);
        mdrive(1, 0, BYTE, 1, 12'hFFF, 0);
        check("ld_top_byte", m_rdata, 32'h000000CA);
        mdrive(1, 0, HALF, 0, 12'hFFE, 0);
        check("ld_top_half", m_rdata, 32'hFFFFCAFE);
        mdrive(0, 0, BYTE, 0, 0, 0);
        mdrive(0, 0, BYTE, 0, 0, 0);
        check("rdata_hold", m_rdata, 32'hFFFFCAFE);

`ifndef DMEM_DUMP_EN
        m_start = 1'b1;
        m_ready = 1'b1;
        mdrive(1, 0, WORD, 0, 12'hFFC, 0);
        m_start = 1'b0;
        check("nodump_ld_rvalid", 32'(m_rvalid), 32'd1);
        check("nodump_ld", m_rdata, 32'hCAFEF00D);
        repeat (3) mdrive(0, 0, BYTE, 0, 0, 0);
`endif

        for (int i = 0; i < 4; i++) sdrive(1, 1, WORD, 0, 4'(4*i), sw[i]);
        sdrive(0, 0, BYTE, 0, 0, 0);

`ifdef DMEM_DUMP_EN
        s_start = 1'b1;
        sdrive(1, 0, WORD, 0, 4'h4, 0);
        s_start = 1'b0;
        check("start_cycle_ld_rvalid", 32'(s_rvalid), 32'd1);
        check("start_cycle_ld", s_rdata, sw[1]);

        k = 0;
        got_done = 1'b0;
        stalled = 1'b0;
        stall_data = '0;
        for (int cyc = 0; cyc < 80 && !got_done; cyc++) begin
            if (s_done) begin
                got_done = 1'b1;
                check("dump_word_count", 32'(k), 32'd4);
                check("dump_done_busy", 32'(s_busy), 32'd1);
            end else begin
                check("dump_busy", 32'(s_busy), 32'd1);
                if (cyc > 0) begin
                    check("dump_req_rvalid", 32'(s_rvalid), 32'd0);
                    check("dump_req_error", 32'(s_error), 32'd0);
                end
                if (s_dvalid && k < 4) begin
                    if (stalled) check("dump_stable", s_ddata, stall_data);
                    check("dump_addr", 32'(s_daddr), 32'(4*k));
                    check("dump_data", s_ddata, sw[k]);
                end
                s_req = (cyc == 0); s_we = 1'b1; s_width = WORD; s_addr = 4'h0;
                s_wdata = 32'hFFFFFFFF;
                s_ready = (cyc % 3 != 0);
                stalled = s_dvalid && !s_ready;
                stall_data = s_ddata;
                if (s_dvalid && s_ready) k++;
                @(negedge clk);
            end
        end
        check("dump_done_seen", 32'(got_done), 32'd1);
        s_req = 1'b0;
        s_ready = 1'b0;
        @(negedge clk);
        check("done_one_cycle", 32'(s_done), 32'd0);
        check("idle_after_done", 32'(s_busy), 32'd0);
        sdrive(1, 0, WORD, 0, 4'h0, 0);
        check("dump_store_dropped", s_rdata, sw[0]);

        s_start = 1'b1;
        s_ready = 1'b1;
        sdrive(0, 0, BYTE, 0, 0, 0);
        s_start = 1'b0;
        k = 0;
        for (int cyc = 0; cyc < 40 && k < 2; cyc++) begin
            if (s_dvalid) k++;
            @(negedge clk);
        end
        check("reset_after_two_words", 32'(k), 32'd2);
        s_rst = 1'b1;
        #1;
        check("mid_reset_busy", 32'(s_busy), 32'd0);
        check("mid_reset_valid", 32'(s_dvalid), 32'd0);
        check("mid_reset_addr", 32'(s_daddr), 32'd0);
        check("mid_reset_data", s_ddata, 32'h0);
        check("mid_reset_rdata", s_rdata, 32'h0);
        @(negedge clk);
        s_rst = 1'b0;
        s_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("post_reset_done", 32'(s_done), 32'd0);
            check("post_reset_busy", 32'(s_busy), 32'd0);
        end
`else
        s_start = 1'b1;
        s_ready = 1'b1;
        sdrive(1, 1, WORD, 0, 4'h8, 32'hDEAD0008);
        s_start = 1'b0;
        sdrive(1, 0, WORD, 0, 4'h8, 0);
        check("nodump_s_rvalid", 32'(s_rvalid), 32'd1);
        check("nodump_s_data", s_rdata, 32'hDEAD0008);
        repeat (3) begin
            check("nodump_busy", 32'(s_busy), 32'd0);
            check("nodump_valid", 32'(s_dvalid), 32'd0);
            check("nodump_done", 32'(s_done), 32'd0);
            check("nodump_addr", 32'(s_daddr), 32'd0);
            check("nodump_ddata", s_ddata, 32'h0);
            sdrive(0, 0, BYTE, 0, 0, 0);
        end
        s_rst = 1'b1;
        @(negedge clk);
        check("reset_s_rdata", s_rdata, 32'h0);
        s_rst = 1'b0;
        @(negedge clk);
`endif

        sdrive(1, 0, WORD, 0, 4'h0, 0);
        check("survive_reset_rvalid", 32'(s_rvalid), 32'd1);
        check("survive_reset_w0", s_rdata, sw[0]);
        sdrive(1, 0, WORD, 0, 4'hC, 0);
        check("survive_reset_w3", s_rdata, sw[3]);
        sdrive(0, 0, BYTE, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
